// File: rtl/impact_sram_pkg.sv
// ============================================================================
// impact_sram_pkg : shared state encoding, default phase timings and helpers
//                   for the IMPACT SRAM bank sequencer.
// Revision        : 1.0
// ============================================================================
`default_nettype none

package impact_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_GUARD = 3'd2,
        ST_WL    = 3'd3,
        ST_SENSE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int unsigned DEF_PRE_CYC   = 2;
    localparam int unsigned DEF_WL_CYC    = 3;
    localparam int unsigned DEF_SENSE_CYC = 1;
    localparam int unsigned CFG_W         = 8;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter holds (length - 1), so it needs clog2(max length) bits, minimum 1.
    function automatic int unsigned cnt_width(input int unsigned max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/impact_phase_timer.sv
// ============================================================================
// impact_phase_timer : loadable down-counter with a done flag, reused by every
//                      timed phase of the bank sequencer.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module impact_phase_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/impact_sram_bank_ctrl.sv
// ============================================================================
// impact_sram_bank_ctrl : ROWS x COLS IMPACT SRAM bank sequencer
//                         (precharge / guard / wordline / sense / done).
// Optional macro        : IMPACT_BANK_MARGIN_EN adds per-request phase lengths.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module impact_sram_bank_ctrl
    import impact_sram_pkg::*;
#(
    parameter int unsigned ROWS      = 32,
    parameter int unsigned COLS      = 32,
    parameter int unsigned ADDR_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int unsigned PRE_CYC   = DEF_PRE_CYC,
    parameter int unsigned WL_CYC    = DEF_WL_CYC,
    parameter int unsigned SENSE_CYC = DEF_SENSE_CYC
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [COLS-1:0]   req_wdata_i,
`ifdef IMPACT_BANK_MARGIN_EN
    input  logic [CFG_W-1:0]  cfg_pre_i,
    input  logic [CFG_W-1:0]  cfg_wl_i,
    input  logic [CFG_W-1:0]  cfg_sense_i,
`endif
    output logic              rsp_valid_o,
    output logic [COLS-1:0]   rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ROWS-1:0]   wl_o,
    output logic              pre_n_o,
    output logic              bl_oe_o,
    output logic [COLS-1:0]   bl_o,
    output logic [COLS-1:0]   blb_o,
    output logic              sae_o,
    input  logic [COLS-1:0]   bl_i,
    input  logic [COLS-1:0]   blb_i
);

`ifdef IMPACT_BANK_MARGIN_EN
    localparam int unsigned MAX_LEN = max3(max3(PRE_CYC, WL_CYC, SENSE_CYC), 255, 1);
`else
    localparam int unsigned MAX_LEN = max3(PRE_CYC, WL_CYC, SENSE_CYC);
`endif
    localparam int unsigned CNT_W = cnt_width(MAX_LEN);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [COLS-1:0]   wdata_q, wdata_d;
    logic [COLS-1:0]   rdata_q, rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic [ROWS-1:0]   wl_q, wl_d;
    logic              pre_n_q, pre_n_d;
    logic              bl_oe_q, bl_oe_d;
    logic [COLS-1:0]   bl_q, bl_d;
    logic [COLS-1:0]   blb_q, blb_d;
    logic              sae_q, sae_d;

    logic              accept;
    logic              in_range;
    logic              sense_bad;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_done;
    logic [CNT_W-1:0]  pre_ld;
    logic [CNT_W-1:0]  wl_ld;
    logic [CNT_W-1:0]  sense_ld;

`ifdef IMPACT_BANK_MARGIN_EN
    logic [CNT_W-1:0]  wl_ld_q, wl_ld_d;
    logic [CNT_W-1:0]  sense_ld_q, sense_ld_d;

    // A zero configuration value falls back to the parameter default.
    function automatic logic [CNT_W-1:0] eff_ld(input logic [CFG_W-1:0] cfg,
                                                input int unsigned    def);
        int unsigned len;
        len = (cfg == '0) ? def : 32'(cfg);
        return CNT_W'(len - 1);
    endfunction

    assign pre_ld   = eff_ld(cfg_pre_i, PRE_CYC);
    assign wl_ld    = wl_ld_q;
    assign sense_ld = sense_ld_q;
`else
    assign pre_ld   = CNT_W'(PRE_CYC - 1);
    assign wl_ld    = CNT_W'(WL_CYC - 1);
    assign sense_ld = CNT_W'(SENSE_CYC - 1);
`endif

    assign accept    = (state_q == ST_IDLE) && req_ready_q && req_valid_i;
    assign in_range  = (32'(req_addr_i) < ROWS);
    // A bit pair that reads equal means the sense amp did not resolve.
    assign sense_bad = |(~(bl_i ^ blb_i));

    impact_phase_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rsp_err_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
`ifdef IMPACT_BANK_MARGIN_EN
        wl_ld_d    = wl_ld_q;
        sense_ld_d = sense_ld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    wdata_d = req_wdata_i;
`ifdef IMPACT_BANK_MARGIN_EN
                    wl_ld_d    = eff_ld(cfg_wl_i, WL_CYC);
                    sense_ld_d = eff_ld(cfg_sense_i, SENSE_CYC);
`endif
                    if (in_range) begin
                        state_d  = ST_PRE;
                        tmr_load = 1'b1;
                        tmr_val  = pre_ld;
                    end else begin
                        state_d   = ST_DONE;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (tmr_done) begin
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                state_d  = ST_WL;
                tmr_load = 1'b1;
                tmr_val  = wl_ld;
            end
            ST_WL: begin
                if (tmr_done) begin
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_SENSE;
                        tmr_load = 1'b1;
                        tmr_val  = sense_ld;
                    end
                end
            end
            ST_SENSE: begin
                if (tmr_done) begin
                    state_d   = ST_DONE;
                    rdata_d   = bl_i;
                    rsp_err_d = sense_bad;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pin drives are decoded from the next state so they register in step with it.
        wl_d = '0;
        if ((state_d == ST_WL) || (state_d == ST_SENSE)) begin
            for (int r = 0; r < ROWS; r++) begin
                wl_d[r] = (addr_q == ADDR_W'(r));
            end
        end
        pre_n_d     = (state_d != ST_PRE);
        bl_oe_d     = (state_d == ST_WL) && we_q;
        bl_d        = bl_oe_d ? wdata_q : '0;
        blb_d       = bl_oe_d ? ~wdata_q : '0;
        sae_d       = (state_d == ST_SENSE);
        rsp_valid_d = (state_d == ST_DONE);
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            wl_q        <= '0;
            pre_n_q     <= 1'b1;
            bl_oe_q     <= 1'b0;
            bl_q        <= '0;
            blb_q       <= '0;
            sae_q       <= 1'b0;
`ifdef IMPACT_BANK_MARGIN_EN
            wl_ld_q     <= '0;
            sense_ld_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            wl_q        <= wl_d;
            pre_n_q     <= pre_n_d;
            bl_oe_q     <= bl_oe_d;
            bl_q        <= bl_d;
            blb_q       <= blb_d;
            sae_q       <= sae_d;
`ifdef IMPACT_BANK_MARGIN_EN
            wl_ld_q     <= wl_ld_d;
            sense_ld_q  <= sense_ld_d;
`endif
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign wl_o        = wl_q;
    assign pre_n_o     = pre_n_q;
    assign bl_oe_o     = bl_oe_q;
    assign bl_o        = bl_q;
    assign blb_o       = blb_q;
    assign sae_o       = sae_q;

endmodule

`default_nettype wire

// File: tb/tb_impact_sram_bank_ctrl.sv
// ============================================================================
// tb_impact_sram_bank_ctrl : randomized self-checking bench for the bank
//                            sequencer (ROWS=20 so out-of-range rows exist).
// Revision                 : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_impact_sram_bank_ctrl;

    localparam int ROWS    = 20;
    localparam int COLS    = 32;
    localparam int AW      = 5;
    localparam int PRE     = 2;
    localparam int WLC     = 3;
    localparam int SNS     = 1;
    localparam int MAXWAIT = 80;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_we = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [COLS-1:0] req_wdata = '0;
    logic [COLS-1:0] bl_in = '0;
    logic [COLS-1:0] blb_in = '1;
    logic            req_ready_o;
    logic            rsp_valid_o;
    logic [COLS-1:0] rsp_rdata_o;
    logic            rsp_err_o;
    logic [ROWS-1:0] wl_o;
    logic            pre_n_o;
    logic            bl_oe_o;
    logic [COLS-1:0] bl_o;
    logic [COLS-1:0] blb_o;
    logic            sae_o;
`ifdef IMPACT_BANK_MARGIN_EN
    logic [7:0]      cfg_pre = '0;
    logic [7:0]      cfg_wl = '0;
    logic [7:0]      cfg_sense = '0;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: row contents as written, and the last completed read value.
    logic [COLS-1:0] mem [ROWS];
    logic [COLS-1:0] last_rdata;

    always #5 clk = ~clk;

    impact_sram_bank_ctrl #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .PRE_CYC   (PRE),
        .WL_CYC    (WLC),
        .SENSE_CYC (SNS)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
`ifdef IMPACT_BANK_MARGIN_EN
        .cfg_pre_i   (cfg_pre),
        .cfg_wl_i    (cfg_wl),
        .cfg_sense_i (cfg_sense),
`endif
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .wl_o        (wl_o),
        .pre_n_o     (pre_n_o),
        .bl_oe_o     (bl_oe_o),
        .bl_o        (bl_o),
        .blb_o       (blb_o),
        .sae_o       (sae_o),
        .bl_i        (bl_in),
        .blb_i       (blb_in)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

`ifdef IMPACT_BANK_MARGIN_EN
    function automatic int eff_len(input logic [7:0] cfg, input int def);
        return (cfg == 8'd0) ? def : int'(cfg);
    endfunction
`endif

    // Issues one request and checks the whole phase timeline against the rules.
    task automatic do_req(input logic we, input logic [AW-1:0] addr,
                          input logic [COLS-1:0] wdata,
                          input logic [COLS-1:0] blv, input logic [COLS-1:0] blbv);
        int p = PRE, w = WLC, s = SNS;
        int waitc = 0, lat = -1, exp_lat;
        int pre_cnt = 0, wl_cnt = 0, first_wl = -1, sae_cnt = 0, oe_cnt = 0;
        bit wl_bad = 0, drv_bad = 0, ovl_bad = 0, rdy_bad = 0;
        bit in_rng, rd;
        logic got_err = 1'b0, exp_err;
        logic [COLS-1:0] got_rd = '0;
        logic [ROWS-1:0] exp_wl;

        while (!req_ready_o && waitc < MAXWAIT) begin
            @(negedge clk);
            waitc++;
        end
        check_val("ready_before_req", 64'(req_ready_o), 64'd1);

        in_rng = (int'(addr) < ROWS);
        rd     = !we;
        exp_wl = in_rng ? (ROWS'(1) << addr) : '0;
`ifdef IMPACT_BANK_MARGIN_EN
        p = eff_len(cfg_pre, PRE);
        w = eff_len(cfg_wl, WLC);
        s = eff_len(cfg_sense, SNS);
`endif
        exp_lat = in_rng ? (p + 1 + w + (rd ? s : 0)) : 0;

        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        bl_in     = blv;
        blb_in    = blbv;
        @(posedge clk);
        @(negedge clk);

        for (int j = 0; j < MAXWAIT; j++) begin
            if (j > 0) @(negedge clk);
            if (!pre_n_o) pre_cnt++;
            if (wl_o != '0) begin
                if (first_wl < 0) first_wl = j;
                wl_cnt++;
                if (wl_o !== exp_wl) wl_bad = 1;
            end
            if (sae_o) sae_cnt++;
            if (bl_oe_o) begin
                oe_cnt++;
                if (bl_o !== wdata || blb_o !== ~wdata) drv_bad = 1;
            end else if (bl_o !== '0 || blb_o !== '0) begin
                drv_bad = 1;
            end
            if ((!pre_n_o && wl_o != '0) || (bl_oe_o && sae_o)) ovl_bad = 1;
            if (req_ready_o) rdy_bad = 1;
            if (j == 0) begin
                // Scramble request inputs: the DUT must use the latched copy.
                req_valid = 1'b0;
                req_we    = 1'($urandom);
                req_addr  = AW'($urandom);
                req_wdata = $urandom;
`ifdef IMPACT_BANK_MARGIN_EN
                cfg_pre   = 8'($urandom_range(0, 5));
                cfg_wl    = 8'($urandom_range(0, 7));
                cfg_sense = 8'($urandom_range(0, 3));
`endif
            end
            if (rsp_valid_o) begin
                lat     = j;
                got_err = rsp_err_o;
                got_rd  = rsp_rdata_o;
                break;
            end
        end

        exp_err = !in_rng || (rd && (|(~(blv ^ blbv))));
        if (in_rng && rd) last_rdata = blv;
        if (in_rng && we) mem[addr] = wdata;

        check_val("latency",   64'(lat),      64'(exp_lat));
        check_val("pre_cycles", 64'(pre_cnt),  64'(in_rng ? p : 0));
        check_val("wl_start",  64'(first_wl), 64'(in_rng ? p + 1 : -1));
        check_val("wl_cycles", 64'(wl_cnt),   64'(in_rng ? w + (rd ? s : 0) : 0));
        check_val("sae_cycles", 64'(sae_cnt),  64'((in_rng && rd) ? s : 0));
        check_val("oe_cycles", 64'(oe_cnt),   64'((in_rng && we) ? w : 0));
        check_val("wl_onehot", 64'(wl_bad),   64'd0);
        check_val("bl_drive",  64'(drv_bad),  64'd0);
        check_val("overlap",   64'(ovl_bad),  64'd0);
        check_val("busy_ready", 64'(rdy_bad),  64'd0);
        check_val("rsp_err",   64'(got_err),  64'(exp_err));
        check_val("rsp_rdata", 64'(got_rd),   64'(last_rdata));

        @(negedge clk);
        check_val("valid_pulse", 64'(rsp_valid_o), 64'd0);
        check_val("idle_ready",  64'(req_ready_o), 64'd1);
    endtask

    task automatic reset_mid_op();
        int waitc = 0;
        bit seen = 0;
        while (!req_ready_o && waitc < MAXWAIT) begin
            @(negedge clk);
            waitc++;
        end
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = AW'(3);
        req_wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        waitc = 0;
        while (wl_o == '0 && waitc < MAXWAIT) begin
            @(negedge clk);
            waitc++;
        end
        check_val("rst_wl_reached", 64'(wl_o != '0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_wl_off",  64'(wl_o),    64'd0);
        check_val("rst_oe_off",  64'(bl_oe_o), 64'd0);
        check_val("rst_bl_off",  64'(bl_o),    64'd0);
        check_val("rst_pre_off", 64'(pre_n_o), 64'd1);
        check_val("rst_ready",   64'(req_ready_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid_o) seen = 1;
        end
        check_val("rst_no_rsp",     64'(seen),        64'd0);
        check_val("rst_ready_back", 64'(req_ready_o), 64'd1);
    endtask

    initial begin
        logic [AW-1:0]   a;
        logic [COLS-1:0] v;
        logic [COLS-1:0] vb;
        logic            we;

        for (int r = 0; r < ROWS; r++) mem[r] = '0;
        last_rdata = '0;

        repeat (3) @(negedge clk);
        check_val("reset_wl",    64'(wl_o),        64'd0);
        check_val("reset_pre_n", 64'(pre_n_o),     64'd1);
        check_val("reset_oe",    64'(bl_oe_o),     64'd0);
        check_val("reset_bl",    64'(bl_o),        64'd0);
        check_val("reset_blb",   64'(blb_o),       64'd0);
        check_val("reset_sae",   64'(sae_o),       64'd0);
        check_val("reset_valid", 64'(rsp_valid_o), 64'd0);
        check_val("reset_err",   64'(rsp_err_o),   64'd0);
        check_val("reset_rdata", 64'(rsp_rdata_o), 64'd0);
        check_val("reset_ready", 64'(req_ready_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b1, AW'(5),  32'hA5A5_5A5A, '0, '1);
        do_req(1'b0, AW'(19), '0, 32'h1234_5678, ~32'h1234_5678);
        do_req(1'b0, AW'(7),  '0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_req(1'b0, AW'(25), '0, 32'hDEAD_BEEF, ~32'hDEAD_BEEF);
        do_req(1'b1, AW'(31), 32'h0F0F_0F0F, '0, '1);
        do_req(1'b0, AW'(5),  '0, mem[5], ~mem[5]);

        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom);
            a  = AW'($urandom_range(0, 31));
`ifdef IMPACT_BANK_MARGIN_EN
            cfg_pre   = 8'($urandom_range(0, 5));
            cfg_wl    = 8'($urandom_range(0, 7));
            cfg_sense = 8'($urandom_range(0, 3));
`endif
            v  = (int'(a) < ROWS) ? mem[a] : $urandom;
            vb = ~v;
            if ($urandom_range(0, 5) == 0) vb[$urandom_range(0, COLS - 1)] ^= 1'b1;
            do_req(we, a, $urandom, v, vb);
        end

`ifdef IMPACT_BANK_MARGIN_EN
        cfg_pre = 8'd0; cfg_wl = 8'd6; cfg_sense = 8'd0;
        do_req(1'b0, AW'(2), '0, mem[2], ~mem[2]);
        cfg_wl = 8'd0;
`endif

        reset_mid_op();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
